// File: rtl/wfg_wishbone_pkg.sv
// -----------------------------------------------------------------------------
// wfg_wishbone_pkg
// Shared constants for the waveform-generator Wishbone register file:
// register word indices, CTRL bit positions, the minimum register count and
// the bus byte-lane width.
// -----------------------------------------------------------------------------
package wfg_wishbone_pkg;

    // Bits per Wishbone byte lane.
    localparam int BYTE_W = 8;

    // Smallest legal register count: CTRL, STATUS, IRQEN and one CFG word.
    localparam int NREG_MIN = 4;

    // Word indices (byte address >> 2).
    localparam int IDX_CTRL   = 0;
    localparam int IDX_STATUS = 1;
    localparam int IDX_IRQEN  = 2;
    localparam int IDX_CFG0   = 3;

    // CTRL bit positions.
    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_UPDATE_BIT  = 1;
    localparam int CTRL_PENDING_BIT = 2;

endpackage : wfg_wishbone_pkg

// File: rtl/wfg_wishbone_bytewrite.sv
// -----------------------------------------------------------------------------
// wfg_wishbone_bytewrite
// One register word whose byte lanes are written independently.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   we        write strobe for this word
//   sel       byte-lane enables, one bit per BYTE_W bits of d
//   d         write data
//   q         current register value
// -----------------------------------------------------------------------------
module wfg_wishbone_bytewrite
    import wfg_wishbone_pkg::*;
#(
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [W/BYTE_W-1:0] sel,
    input  logic [W-1:0]        d,
    output logic [W-1:0]        q
);

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (we) begin
            for (int b = 0; b < W / BYTE_W; b++) begin
                if (sel[b]) q[b*BYTE_W +: BYTE_W] <= d[b*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule : wfg_wishbone_bytewrite

// File: rtl/wfg_wishbone_regfile.sv
// -----------------------------------------------------------------------------
// wfg_wishbone_regfile
// Wishbone slave register file for the waveform generator core.
//   word 0  CTRL    bit0 EN (RW), bit1 UPDATE (write-only pulse), bit2 PENDING (RO)
//   word 1  STATUS  sticky event bits, write 1 to clear
//   word 2  IRQEN   interrupt enables for STATUS
//   word 3+ CFG     shadowed configuration; shadows commit to the active copy
//                   on sync_i (or immediately while EN=0) after UPDATE
// Ports:
//   wb_clk_i, wb_rst_i           clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i/sel_i/adr_i/dat_i   Wishbone request
//   wbs_ack_o, wbs_err_o, wbs_dat_o           registered response
//   sync_i        core frame boundary pulse
//   evt_i         core event pulses
//   ctrl_en_q_o   CTRL.EN
//   cfg_q_o       active CFG words, word 3 in the LSBs
//   irq_o         registered interrupt
// -----------------------------------------------------------------------------
module wfg_wishbone_regfile
    import wfg_wishbone_pkg::*;
#(
    parameter int BUSW = 32,
    parameter int NREG = 8,
    parameter int NEVT = 8
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        wbs_cyc_i,
    input  logic                        wbs_stb_i,
    input  logic                        wbs_we_i,
    input  logic [BUSW/8-1:0]           wbs_sel_i,
    input  logic [BUSW-1:0]             wbs_adr_i,
    input  logic [BUSW-1:0]             wbs_dat_i,
    output logic                        wbs_ack_o,
    output logic                        wbs_err_o,
    output logic [BUSW-1:0]             wbs_dat_o,
    input  logic                        sync_i,
    input  logic [NEVT-1:0]             evt_i,
    output logic                        ctrl_en_q_o,
    output logic [(NREG-3)*BUSW-1:0]    cfg_q_o,
    output logic                        irq_o
);

    localparam int NCFG = NREG - IDX_CFG0;
    localparam int IW   = BUSW - 2;

    if (NREG < NREG_MIN) begin : g_nreg_check
        $error("wfg_wishbone_regfile: NREG below minimum");
    end

    logic [IW-1:0]          word_idx;
    logic                   addr_ok;
    logic                   done;
    logic                   req, wr, rd;
    logic                   wr_ctrl, wr_status, wr_irqen;
    logic                   update_wr, commit;
    logic                   en, pending;
    logic [NEVT-1:0]        status, irqen, status_clr;
    logic [NCFG*BUSW-1:0]   cfg_shadow, cfg_active;
    logic [BUSW-1:0]        read_data;

    assign word_idx = wbs_adr_i[BUSW-1:2];
    assign addr_ok  = (wbs_adr_i[1:0] == 2'b00) && (word_idx < IW'(NREG));

    // 'done' remembers that the strobe currently held has already been
    // answered; it covers the ack/err cycle and any cycles the master keeps
    // stb high afterwards, so one strobe is one transfer.
    assign req = wbs_cyc_i & wbs_stb_i & ~done;
    assign wr  = req &  wbs_we_i & addr_ok;
    assign rd  = req & ~wbs_we_i & addr_ok;

    assign wr_ctrl   = wr && (word_idx == IW'(IDX_CTRL));
    assign wr_status = wr && (word_idx == IW'(IDX_STATUS));
    assign wr_irqen  = wr && (word_idx == IW'(IDX_IRQEN));

    assign update_wr = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[CTRL_UPDATE_BIT];
    assign commit    = pending & (sync_i | ~en);

    // NOTE: every variable driven from always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        status_clr = '0;
        for (int i = 0; i < NEVT; i++) begin
            status_clr[i] = wr_status & wbs_sel_i[i/BYTE_W] & wbs_dat_i[i];
        end
    end

    always_comb begin
        read_data = '0;
        if (word_idx == IW'(IDX_CTRL)) begin
            read_data[CTRL_EN_BIT]      = en;
            read_data[CTRL_PENDING_BIT] = pending;
        end else if (word_idx == IW'(IDX_STATUS)) begin
            read_data[NEVT-1:0] = status;
        end else if (word_idx == IW'(IDX_IRQEN)) begin
            read_data[NEVT-1:0] = irqen;
        end else begin
            for (int i = 0; i < NCFG; i++) begin
                if (word_idx == IW'(IDX_CFG0 + i)) read_data = cfg_shadow[i*BUSW +: BUSW];
            end
        end
    end

    // Shadow CFG words: written by the bus, read back by the bus.
    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        wfg_wishbone_bytewrite #(.W(BUSW)) u_word (
            .clk (wb_clk_i),
            .rst (wb_rst_i),
            .we  (wr && (word_idx == IW'(IDX_CFG0 + g))),
            .sel (wbs_sel_i),
            .d   (wbs_dat_i),
            .q   (cfg_shadow[g*BUSW +: BUSW])
        );
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            done       <= 1'b0;
            wbs_ack_o  <= 1'b0;
            wbs_err_o  <= 1'b0;
            wbs_dat_o  <= '0;
            en         <= 1'b0;
            pending    <= 1'b0;
            status     <= '0;
            irqen      <= '0;
            cfg_active <= '0;
            irq_o      <= 1'b0;
        end else begin
            done      <= wbs_cyc_i & wbs_stb_i;
            wbs_ack_o <= req &  addr_ok;
            wbs_err_o <= req & ~addr_ok;
            wbs_dat_o <= rd ? read_data : '0;

            if (wr_ctrl && wbs_sel_i[0]) en <= wbs_dat_i[CTRL_EN_BIT];

            // A fresh UPDATE wins over a commit landing in the same cycle.
            if (update_wr)   pending <= 1'b1;
            else if (commit) pending <= 1'b0;

            // Takes the shadow as it was before any write at this same edge.
            if (commit) cfg_active <= cfg_shadow;

            // Set beats clear when an event and a W1C write coincide.
            status <= (status & ~status_clr) | evt_i;

            if (wr_irqen) begin
                for (int i = 0; i < NEVT; i++) begin
                    if (wbs_sel_i[i/BYTE_W]) irqen[i] <= wbs_dat_i[i];
                end
            end

            irq_o <= |(status & irqen);
        end
    end

    assign ctrl_en_q_o = en;
    assign cfg_q_o     = cfg_active;

endmodule : wfg_wishbone_regfile

// File: tb/tb_wfg_wishbone_regfile.sv
// -----------------------------------------------------------------------------
// tb_wfg_wishbone_regfile
// Self-checking bench for wfg_wishbone_regfile (BUSW=32, NREG=8, NEVT=8).
// A behavioural model keeps the register contents as plain arrays and is
// updated from the register-map rules; every DUT observation is compared
// against it or against constants.
// -----------------------------------------------------------------------------
module tb_wfg_wishbone_regfile;

    localparam int BUSW = 32;
    localparam int NREG = 8;
    localparam int NEVT = 8;
    localparam int NCFG = NREG - 3;

    logic                     wb_clk_i = 1'b0;
    logic                     wb_rst_i = 1'b1;
    logic                     wbs_cyc_i = 1'b0;
    logic                     wbs_stb_i = 1'b0;
    logic                     wbs_we_i = 1'b0;
    logic [BUSW/8-1:0]        wbs_sel_i = '0;
    logic [BUSW-1:0]          wbs_adr_i = '0;
    logic [BUSW-1:0]          wbs_dat_i = '0;
    logic                     wbs_ack_o;
    logic                     wbs_err_o;
    logic [BUSW-1:0]          wbs_dat_o;
    logic                     sync_i = 1'b0;
    logic [NEVT-1:0]          evt_i = '0;
    logic                     ctrl_en_q_o;
    logic [NCFG*BUSW-1:0]     cfg_q_o;
    logic                     irq_o;

    always #5 wb_clk_i = ~wb_clk_i;

    wfg_wishbone_regfile #(.BUSW(BUSW), .NREG(NREG), .NEVT(NEVT)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_err_o   (wbs_err_o),
        .wbs_dat_o   (wbs_dat_o),
        .sync_i      (sync_i),
        .evt_i       (evt_i),
        .ctrl_en_q_o (ctrl_en_q_o),
        .cfg_q_o     (cfg_q_o),
        .irq_o       (irq_o)
    );

    int checks = 0;
    int fails  = 0;

    // ---------------- behavioural model ----------------
    logic [31:0] m_shadow [NREG];
    logic [31:0] m_active [NREG];
    logic        m_en, m_pending;
    logic [7:0]  m_status, m_irqen;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        m_en = 0; m_pending = 0; m_status = '0; m_irqen = '0;
    endtask

    function automatic logic [31:0] model_read(input int idx);
        case (idx)
            0:       return {29'd0, m_pending, 1'b0, m_en};
            1:       return {24'd0, m_status};
            2:       return {24'd0, m_irqen};
            default: return m_shadow[idx];
        endcase
    endfunction

    task automatic model_write(input int idx, input logic [3:0] sel, input logic [31:0] dat);
        logic [31:0] m;
        m = lane_mask(sel);
        if (idx == 0) begin
            if (sel[0]) begin
                m_en = dat[0];
                if (dat[1]) m_pending = 1'b1;
            end
        end else if (idx == 1) begin
            m_status = m_status & ~(dat[7:0] & m[7:0]);
        end else if (idx == 2) begin
            m_irqen = (m_irqen & ~m[7:0]) | (dat[7:0] & m[7:0]);
        end else begin
            m_shadow[idx] = (m_shadow[idx] & ~m) | (dat & m);
        end
    endtask

    task automatic model_commit();
        for (int i = 3; i < NREG; i++) m_active[i] = m_shadow[i];
        m_pending = 1'b0;
    endtask

    function automatic logic [NCFG*BUSW-1:0] model_cfg_q();
        logic [NCFG*BUSW-1:0] r;
        for (int i = 0; i < NCFG; i++) r[i*BUSW +: BUSW] = m_active[i+3];
        return r;
    endfunction

    // One Wishbone transfer plus one idle cycle. Called #1 after a rising
    // edge; returns #1 after a rising edge. sync/evt are applied only in
    // the request cycle. The response is sampled exactly one cycle after
    // the request.
    task automatic bus(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, input logic sync, input logic [7:0] evt,
                       output logic [31:0] rdata, output logic ack, output logic err);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_sel_i = sel; wbs_dat_i = dat;
        sync_i = sync; evt_i = evt;
        @(posedge wb_clk_i); #1;
        ack = wbs_ack_o; err = wbs_err_o; rdata = wbs_dat_o;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        sync_i = 1'b0; evt_i = '0;
        @(posedge wb_clk_i); #1;
    endtask

    // Read one valid index and compare against the model.
    task automatic read_expect(input int idx, input string name);
        logic [31:0] rd; logic ack, err;
        bus(1'b0, 32'(idx * 4), 4'hF, 32'h0, 1'b0, 8'h0, rd, ack, err);
        checks++;
        if (rd !== model_read(idx) || ack !== 1'b1 || err !== 1'b0) begin
            fails++;
            $display("FAIL %s idx=%0d: got data=%h ack=%b err=%b, want data=%h ack=1 err=0",
                     name, idx, rd, ack, err, model_read(idx));
        end
    endtask

    task automatic write_reg(input int idx, input logic [3:0] sel, input logic [31:0] dat,
                             input logic sync, input logic [7:0] evt);
        logic [31:0] rd; logic ack, err;
        bus(1'b1, 32'(idx * 4), sel, dat, sync, evt, rd, ack, err);
        checks++;
        if (ack !== 1'b1 || err !== 1'b0) begin
            fails++;
            $display("FAIL write_ack idx=%0d: got ack=%b err=%b, want ack=1 err=0", idx, ack, err);
        end
    endtask

    task automatic pulse_sync();
        sync_i = 1'b1;
        @(posedge wb_clk_i); #1;
        sync_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        wb_rst_i = 1'b1;
        model_reset();
        repeat (3) @(posedge wb_clk_i);
        #1;
        checks++;
        if ({wbs_ack_o, wbs_err_o, irq_o, ctrl_en_q_o} !== 4'b0 || wbs_dat_o !== '0 || cfg_q_o !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got ack=%b err=%b irq=%b en=%b dat=%h cfg=%h, want all 0",
                     wbs_ack_o, wbs_err_o, irq_o, ctrl_en_q_o, wbs_dat_o, cfg_q_o);
        end
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i); #1;
        for (int i = 0; i < NREG; i++) read_expect(i, "reset_read");

        // Reset arriving while a request is outstanding aborts it.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 32'h0C; wbs_sel_i = 4'hF; wbs_dat_i = 32'hFFFF_FFFF;
        #2 wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i); #1;
        checks++;
        if (wbs_ack_o !== 1'b0 || wbs_err_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_abort: got ack=%b err=%b, want 0 0", wbs_ack_o, wbs_err_o);
        end
        read_expect(3, "reset_abort_cfg3");
    endtask

    task automatic test_byte_write();
        write_reg(3, 4'b0101, 32'hA5A5_A5A5, 1'b0, 8'h0);
        model_write(3, 4'b0101, 32'hA5A5_A5A5);
        checks++;
        if (model_read(3) !== 32'h00A5_00A5) begin
            fails++;
            $display("FAIL byte_model: got %h want 00a500a5", model_read(3));
        end
        read_expect(3, "byte_write_read");
        checks++;
        if (cfg_q_o[31:0] !== 32'h0) begin
            fails++;
            $display("FAIL byte_write_active: got %h want 00000000", cfg_q_o[31:0]);
        end
        write_reg(4, 4'b0000, 32'hFFFF_FFFF, 1'b0, 8'h0);
        read_expect(4, "sel_zero_no_change");
    endtask

    task automatic test_shadow_commit();
        write_reg(0, 4'h1, 32'h1, 1'b0, 8'h0); model_write(0, 4'h1, 32'h1);
        write_reg(0, 4'h1, 32'h3, 1'b0, 8'h0); model_write(0, 4'h1, 32'h3);
        repeat (10) @(posedge wb_clk_i);
        #1;
        read_expect(0, "pending_held");
        checks++;
        if (cfg_q_o !== model_cfg_q()) begin
            fails++;
            $display("FAIL active_before_sync: got %h want %h", cfg_q_o, model_cfg_q());
        end
        pulse_sync(); model_commit();
        checks++;
        if (cfg_q_o[31:0] !== 32'h00A5_00A5 || cfg_q_o !== model_cfg_q()) begin
            fails++;
            $display("FAIL commit_on_sync: got %h want %h", cfg_q_o, model_cfg_q());
        end
        read_expect(0, "pending_cleared");

        // Shadow write coinciding with the commit lands in the shadow only.
        write_reg(0, 4'h1, 32'h3, 1'b0, 8'h0); model_write(0, 4'h1, 32'h3);
        write_reg(4, 4'hF, 32'h1122_3344, 1'b1, 8'h0);
        model_commit(); model_write(4, 4'hF, 32'h1122_3344);
        checks++;
        if (cfg_q_o !== model_cfg_q()) begin
            fails++;
            $display("FAIL commit_vs_write: got %h want %h", cfg_q_o, model_cfg_q());
        end
        read_expect(4, "commit_vs_write_shadow");

        // UPDATE while already pending: still one pending commit.
        write_reg(0, 4'h1, 32'h3, 1'b0, 8'h0); model_write(0, 4'h1, 32'h3);
        write_reg(0, 4'h1, 32'h3, 1'b0, 8'h0); model_write(0, 4'h1, 32'h3);
        read_expect(0, "double_update_pending");
        pulse_sync(); model_commit();
        read_expect(0, "double_update_cleared");
        checks++;
        if (cfg_q_o[63:32] !== 32'h1122_3344) begin
            fails++;
            $display("FAIL double_update_active: got %h want 11223344", cfg_q_o[63:32]);
        end

        // With EN=0 a pending update commits without sync.
        write_reg(3, 4'b1000, 32'hFFFF_FFFF, 1'b0, 8'h0); model_write(3, 4'b1000, 32'hFFFF_FFFF);
        write_reg(0, 4'h1, 32'h2, 1'b0, 8'h0); model_write(0, 4'h1, 32'h2); model_commit();
        checks++;
        if (cfg_q_o[31:0] !== 32'hFFA5_00A5 || ctrl_en_q_o !== 1'b0) begin
            fails++;
            $display("FAIL commit_en0: got cfg=%h en=%b want ffa500a5 en=0", cfg_q_o[31:0], ctrl_en_q_o);
        end
        read_expect(0, "commit_en0_ctrl");
    endtask

    task automatic test_events_irq();
        write_reg(2, 4'h1, 32'h04, 1'b0, 8'h0); model_write(2, 4'h1, 32'h04);
        evt_i = 8'h04;
        @(posedge wb_clk_i); #1;
        evt_i = 8'h00; m_status = m_status | 8'h04;
        checks++;
        if (irq_o !== 1'b0) begin
            fails++;
            $display("FAIL irq_latency: got irq=%b want 0 one cycle after the event", irq_o);
        end
        @(posedge wb_clk_i); #1;
        checks++;
        if (irq_o !== 1'b1) begin
            fails++;
            $display("FAIL irq_rise: got %b want 1", irq_o);
        end
        read_expect(1, "status_set");
        write_reg(1, 4'h1, 32'h04, 1'b0, 8'h04);
        model_write(1, 4'h1, 32'h04); m_status = m_status | 8'h04;
        read_expect(1, "status_set_wins");
        write_reg(1, 4'h1, 32'h04, 1'b0, 8'h0); model_write(1, 4'h1, 32'h04);
        read_expect(1, "status_cleared");
        checks++;
        if (irq_o !== 1'b0) begin
            fails++;
            $display("FAIL irq_fall: got %b want 0", irq_o);
        end
        // Event on a bit that is not enabled: sticky but no interrupt.
        evt_i = 8'h10;
        @(posedge wb_clk_i); #1;
        evt_i = 8'h00; m_status = m_status | 8'h10;
        @(posedge wb_clk_i); #1;
        checks++;
        if (irq_o !== 1'b0) begin
            fails++;
            $display("FAIL irq_masked: got %b want 0", irq_o);
        end
        read_expect(1, "status_masked_bit");
        write_reg(1, 4'h1, 32'h10, 1'b0, 8'h0); model_write(1, 4'h1, 32'h10);
    endtask

    task automatic test_err();
        logic [31:0] rd; logic ack, err;
        logic [31:0] adrs [4];
        logic        wes  [4];
        adrs[0] = 32'h40; wes[0] = 1'b0;
        adrs[1] = 32'h06; wes[1] = 1'b0;
        adrs[2] = 32'h40; wes[2] = 1'b1;
        adrs[3] = 32'h0E; wes[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus(wes[k], adrs[k], 4'hF, 32'hFFFF_FFFF, 1'b0, 8'h0, rd, ack, err);
            checks++;
            if (err !== 1'b1 || ack !== 1'b0 || rd !== 32'h0) begin
                fails++;
                $display("FAIL bad_address adr=%h we=%b: got err=%b ack=%b data=%h, want err=1 ack=0 data=0",
                         adrs[k], wes[k], err, ack, rd);
            end
        end
        for (int i = 0; i < NREG; i++) read_expect(i, "after_err_read");
        checks++;
        if (cfg_q_o !== model_cfg_q()) begin
            fails++;
            $display("FAIL after_err_active: got %h want %h", cfg_q_o, model_cfg_q());
        end
    endtask

    task automatic test_held_strobe();
        int acks;
        acks = 0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 32'h14; wbs_sel_i = 4'hF; wbs_dat_i = 32'h0000_00FF;
        for (int c = 0; c < 5; c++) begin
            @(posedge wb_clk_i); #1;
            if (wbs_ack_o === 1'b1) acks++;
            wbs_dat_i = 32'hDEAD_0000;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(posedge wb_clk_i); #1;
        model_write(5, 4'hF, 32'h0000_00FF);
        checks++;
        if (acks != 1) begin
            fails++;
            $display("FAIL held_strobe_acks: got %0d acks want 1", acks);
        end
        read_expect(5, "held_strobe_single_write");
    endtask

    task automatic test_random();
        logic [31:0] dat;
        logic [3:0]  sel;
        int idx, op;
        for (int n = 0; n < 40; n++) begin
            op  = int'($urandom_range(0, 1));
            idx = int'($urandom_range(1, NREG - 1));
            dat = $urandom;
            sel = 4'($urandom);
            if (op == 0) begin
                write_reg(idx, sel, dat, 1'b0, 8'h0);
                model_write(idx, sel, dat);
            end else begin
                read_expect(int'($urandom_range(0, NREG - 1)), "random_read");
            end
        end
        checks++;
        if (irq_o !== |(m_status & m_irqen) || cfg_q_o !== model_cfg_q()) begin
            fails++;
            $display("FAIL random_state: got irq=%b cfg=%h want irq=%b cfg=%h",
                     irq_o, cfg_q_o, |(m_status & m_irqen), model_cfg_q());
        end
        write_reg(0, 4'h1, 32'h3, 1'b0, 8'h0); model_write(0, 4'h1, 32'h3);
        pulse_sync(); model_commit();
        checks++;
        if (cfg_q_o !== model_cfg_q()) begin
            fails++;
            $display("FAIL random_commit: got %h want %h", cfg_q_o, model_cfg_q());
        end
        read_expect(0, "random_ctrl");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_byte_write();
        test_shadow_commit();
        test_events_irq();
        test_err();
        test_held_strobe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_wfg_wishbone_regfile
